// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcodes, sequencer states, canonical NaN and operand pre-check
package fpu_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_QUO  = 3'b011,
    OP_SQRT = 3'b100,
    OP_REM  = 3'b101
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_e;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  function automatic logic [32:0] precheck(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2:1] == 2'b11 ? {1'b1, 32'h0} :
           (op == OP_QUO || op == OP_REM) && b[30:0] == 31'h0 ? {1'b1, CANON_NAN} :
           op == OP_SQRT && a[31] && a[30:0] != 31'h0 ? {1'b1, CANON_NAN} : 33'h0;
  endfunction
endpackage

// File: rtl/fpu_sequencer_if.sv
// fpu_sequencer_if: command, result and flu datapath signals of the sequencer
interface fpu_sequencer_if;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic        fpu_s, fpu_s0;
  logic [7:0]  fpu_e, fpu_e0;
  logic [22:0] fpu_m, fpu_m0;
  logic [31:0] fpu_add, fpu_sub, fpu_mul, fpu_quo, fpu_rem, fpu_sr;
  logic        res_valid, res_ready, res_err;
  logic [31:0] res_data;
  logic [2:0]  res_op;
  logic        busy;
  logic [15:0] op_count;
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output fpu_add, fpu_sub, fpu_mul, fpu_quo, fpu_rem, fpu_sr,
    input  cmd_ready, fpu_s, fpu_e, fpu_m, fpu_s0, fpu_e0, fpu_m0,
    input  res_valid, res_data, res_op, res_err, busy, op_count
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  fpu_add, fpu_sub, fpu_mul, fpu_quo, fpu_rem, fpu_sr,
    output cmd_ready, fpu_s, fpu_e, fpu_m, fpu_s0, fpu_e0, fpu_m0,
    output res_valid, res_data, res_op, res_err, busy, op_count
  );
endinterface

// File: rtl/fpu_result_mux.sv
// fpu_result_mux: selects the flu result matching the latched opcode
module fpu_result_mux
  import fpu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_add,
  input  logic [31:0] i_sub,
  input  logic [31:0] i_mul,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_rem,
  input  logic [31:0] i_sr,
  output logic [31:0] o_res
);
  assign o_res = i_op == OP_ADD  ? i_add :
                 i_op == OP_SUB  ? i_sub :
                 i_op == OP_MUL  ? i_mul :
                 i_op == OP_QUO  ? i_quo :
                 i_op == OP_SQRT ? i_sr  :
                 i_op == OP_REM  ? i_rem : 32'h0;
endmodule

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: accepts fp commands, holds operands on the flu for a settle time, returns the selected result
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic            clk,
  input logic            rst_n,
  fpu_sequencer_if.slave bus
);
  state_e      r_state;
  logic        r_cmd_ready, r_busy, r_res_valid, r_res_err;
  logic [3:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_res_data;
  logic [15:0] r_op_count;
  logic [31:0] w_mux, w_err_data;
  logic        w_err, w_accept, w_done;
  assign w_accept = bus.cmd_valid && r_cmd_ready;
  assign w_done = r_res_valid && bus.res_ready;
  assign {w_err, w_err_data} = precheck(bus.cmd_op, bus.cmd_a, bus.cmd_b);
  fpu_result_mux u_mux (
    .i_op (r_op),
    .i_add(bus.fpu_add),
    .i_sub(bus.fpu_sub),
    .i_mul(bus.fpu_mul),
    .i_quo(bus.fpu_quo),
    .i_rem(bus.fpu_rem),
    .i_sr (bus.fpu_sr),
    .o_res(w_mux)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_data  <= 32'h0;
      r_op        <= 3'h0;
      r_cnt       <= 4'h0;
      r_a         <= 32'h0;
      r_b         <= 32'h0;
      r_op_count  <= 16'h0;
    end else begin
      case (r_state)
        S_IDLE:
          if (w_accept) begin
            r_op        <= bus.cmd_op;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_err) begin
              r_state     <= S_DONE;
              r_res_valid <= 1'b1;
              r_res_data  <= w_err_data;
              r_res_err   <= 1'b1;
            end else begin
              r_state <= S_SETTLE;
              r_a     <= bus.cmd_a;
              r_b     <= bus.cmd_b;
              r_cnt   <= 4'(SETTLE_CYCLES);
            end
          end else r_cmd_ready <= 1'b1;
        S_SETTLE:
          if (r_cnt == 4'd1) begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
            r_res_data  <= w_mux;
            r_res_err   <= 1'b0;
            r_cnt       <= 4'h0;
          end else r_cnt <= r_cnt - 4'd1;
        S_DONE:
          if (w_done) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_op_count  <= r_op_count + 16'd1;
          end
        default: r_state <= S_IDLE;
      endcase
    end
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.busy = r_busy;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data = r_res_data;
  assign bus.res_op = r_op;
  assign bus.res_err = r_res_err;
  assign bus.op_count = r_op_count;
  assign {bus.fpu_s, bus.fpu_e, bus.fpu_m} = r_a;
  assign {bus.fpu_s0, bus.fpu_e0, bus.fpu_m0} = r_b;
endmodule
